// File: rtl/clic_pend_writer.sv
// Queues interrupt edges and core clears as sticky per-source flags and drains them round-robin
// as read-modify-write updates of the pending bit in the CSR table. Optional: CLIC_PEND_SYNC_EN.
module clic_pend_writer #(
    parameter type CsrDataT = logic [7:0],
    parameter int NumIrq = 16,
    parameter int PendBit = 0,
    localparam int IdxBits = $clog2(NumIrq)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NumIrq-1:0]  irq,
    input  logic               clear_valid,
    input  logic [IdxBits-1:0] clear_idx,
    input  CsrDataT            entry_in [NumIrq],
    output CsrDataT            ext_data,
    output logic               ext_write_enable,
    output logic [IdxBits-1:0] ext_idx,
    output logic               busy,
    output logic               overflow
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t             state, state_nxt;
    logic [NumIrq-1:0]  irq_s, irq_prev, irq_edge;
    logic [NumIrq-1:0]  set_flag, clr_flag, clr_req, taken, pending;
    logic [IdxBits-1:0] rr_ptr, sel_idx, pick_idx, cand_idx;
    logic               sel_set, found;
    int                 scan_j;

`ifdef CLIC_PEND_SYNC_EN
    logic [NumIrq-1:0] sync_p0, sync_p1;

    // Two-flop synchronizer stage ahead of edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= irq;
            sync_p1 <= sync_p0;
        end
    end
    assign irq_s = sync_p1;
`else
    assign irq_s = irq;
`endif

    assign irq_edge = irq_s & ~irq_prev;
    assign pending  = set_flag | clr_flag;
    assign busy     = (state == WRITE) | (|set_flag) | (|clr_flag);

    // Round-robin scan starting at rr_ptr; first pending source wins
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        scan_j   = 0;
        cand_idx = '0;
        for (int k = 0; k < NumIrq; k++) begin
            scan_j = int'(rr_ptr) + k;
            if (scan_j >= NumIrq) scan_j = scan_j - NumIrq;
            cand_idx = IdxBits'(scan_j);
            if (!found && pending[cand_idx]) begin
                found    = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    always_comb begin
        taken   = '0;
        clr_req = '0;
        if (found) taken[pick_idx] = 1'b1;
        for (int i = 0; i < NumIrq; i++) begin
            clr_req[i] = clear_valid && (int'(clear_idx) == i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            irq_prev <= '0;
            set_flag <= '0;
            clr_flag <= '0;
            rr_ptr   <= '0;
            sel_idx  <= '0;
            sel_set  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            irq_prev <= irq_s;
            // A new event arriving while its flag is taken re-arms the flag
            set_flag <= irq_edge | (set_flag & ~taken);
            clr_flag <= clr_req | (clr_flag & ~taken);
            if (|(irq_edge & set_flag & ~taken)) overflow <= 1'b1;
            if (found) begin
                sel_idx <= pick_idx;
                sel_set <= set_flag[pick_idx];
                rr_ptr  <= (pick_idx == IdxBits'(NumIrq - 1)) ? '0 : pick_idx + IdxBits'(1);
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        ext_write_enable = 1'b0;
        ext_idx          = '0;
        ext_data         = '0;
        case (state)
            IDLE: begin
                if (found) state_nxt = WRITE;
            end
            WRITE: begin
                ext_write_enable  = 1'b1;
                ext_idx           = sel_idx;
                // Live entry read back so only the pending bit changes
                ext_data          = entry_in[sel_idx];
                ext_data[PendBit] = sel_set;
                state_nxt         = found ? WRITE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_clic_pend_writer.sv
// Bench for clic_pend_writer: random traffic against a request-set reference model, then directed cases.
module tb_clic_pend_writer;
    localparam int N  = 16;
    localparam int PB = 0;
`ifdef CLIC_PEND_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] irq;
    logic        clear_valid;
    logic [3:0]  clear_idx;
    logic [7:0]  tbl [N];
    logic [7:0]  ext_data;
    logic        ext_write_enable;
    logic [3:0]  ext_idx;
    logic        busy, overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending request sets, a write slot, a round-robin start index
    bit          m_write;
    int          m_sel;
    bit          m_sel_set;
    int          m_rr;
    bit [15:0]   m_set, m_clr, m_prev, m_s1, m_s2;
    bit          m_ovf;

    logic        obs_we, obs_busy, obs_ovf;
    logic [3:0]  obs_idx;
    logic [7:0]  obs_data;

    always #5 clk = ~clk;

    clic_pend_writer dut (
        .clk(clk), .reset(reset), .irq(irq), .clear_valid(clear_valid), .clear_idx(clear_idx),
        .entry_in(tbl), .ext_data(ext_data), .ext_write_enable(ext_write_enable),
        .ext_idx(ext_idx), .busy(busy), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_write = 0; m_sel = 0; m_sel_set = 0; m_rr = 0;
        m_set = '0; m_clr = '0; m_prev = '0; m_s1 = '0; m_s2 = '0; m_ovf = 0;
    endtask

    function automatic logic [7:0] exp_data();
        logic [7:0] d;
        if (!m_write) return 8'h00;
        d = tbl[m_sel];
        d[PB] = m_sel_set;
        return d;
    endfunction

    task automatic check_outputs();
        obs_we = ext_write_enable; obs_idx = ext_idx; obs_data = ext_data;
        obs_busy = busy; obs_ovf = overflow;
        chk("we",   obs_we,   m_write);
        chk("idx",  obs_idx,  m_write ? m_sel : 0);
        chk("data", obs_data, exp_data());
        chk("busy", obs_busy, m_write || (|m_set) || (|m_clr));
        chk("ovf",  obs_ovf,  m_ovf);
    endtask

    task automatic step();
        bit [15:0] src, edges, taken, creq;
        int pick, j;
        bit w_en;
        int w_idx;
        logic [7:0] w_dat;
        src   = (SL != 0) ? m_s2 : irq;
        edges = src & ~m_prev;
        pick  = -1;
        for (int k = 0; k < N; k++) begin
            j = (m_rr + k) % N;
            if (pick < 0 && (m_set[j] || m_clr[j])) pick = j;
        end
        taken = '0;
        if (pick >= 0) taken[pick] = 1'b1;
        creq = '0;
        if (clear_valid) creq[clear_idx] = 1'b1;
        w_en = m_write; w_idx = m_sel; w_dat = exp_data();
        @(posedge clk);
        if (reset) model_reset();
        else begin
            if (w_en) tbl[w_idx] = w_dat;
            if (|(edges & m_set & ~taken)) m_ovf = 1;
            if (pick >= 0) begin
                m_sel = pick; m_sel_set = m_set[pick]; m_rr = (pick + 1) % N;
            end
            m_write = (pick >= 0);
            m_set = edges | (m_set & ~taken);
            m_clr = creq | (m_clr & ~taken);
            m_s2 = m_s1; m_s1 = irq; m_prev = src;
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic go_idle();
        irq = '0; clear_valid = 1'b0;
        repeat (SL + 3) step();
        for (int i = 0; i < 60 && obs_busy; i++) step();
        chk("idle_busy", obs_busy, 1'b0);
    endtask

    initial begin
        int cnt, cnt7;
        logic [7:0] e3, d5;
        reset = 1'b1; irq = '0; clear_valid = 1'b0; clear_idx = '0;
        for (int i = 0; i < N; i++) tbl[i] = 8'($urandom);
        model_reset();
        #1;
        check_outputs();
        do_reset();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) irq[b] = ~irq[b];
            clear_valid = ($urandom_range(3) == 0);
            clear_idx   = 4'($urandom);
            step();
        end
        go_idle();

        // Single rising edge on irq[3]
        do_reset();
        step(); step();
        e3 = tbl[3] | 8'h01;
        irq[3] = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 6 + SL; k++) begin
            step();
            if (obs_we) cnt++;
            if (k == 1 + SL) chk("t1_early", obs_we, 1'b0);
            if (k == 2 + SL) begin
                chk("t1_we", obs_we, 1'b1);
                chk("t1_idx", obs_idx, 4'd3);
                chk("t1_data", obs_data, e3);
            end
        end
        chk("t1_cnt", cnt, 1);
        go_idle();

        // Round-robin order from rr_ptr=10
        irq[9] = 1'b1;
        repeat (6 + SL) step();
        go_idle();
        irq = 16'h4204;
        for (int k = 1; k <= 6 + SL; k++) begin
            step();
            if (k == 2 + SL) chk("t2_idx_a", obs_idx, 4'd14);
            if (k == 3 + SL) chk("t2_idx_b", obs_idx, 4'd2);
            if (k == 4 + SL) begin
                chk("t2_idx_c", obs_idx, 4'd9);
                chk("t2_busy_last", obs_busy, 1'b1);
            end
            if (k == 5 + SL) begin
                chk("t2_we_after", obs_we, 1'b0);
                chk("t2_busy_after", obs_busy, 1'b0);
            end
        end
        go_idle();

        // Clear of index 5 on an entry with the pending bit set
        tbl[5] = 8'hA1;
        clear_valid = 1'b1; clear_idx = 4'd5;
        cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            clear_valid = 1'b0;
            if (obs_we) cnt++;
            if (k == 2) begin
                chk("t3_idx", obs_idx, 4'd5);
                chk("t3_data", obs_data, 8'hA0);
            end
        end
        chk("t3_cnt", cnt, 1);
        go_idle();

        // Edge and clear of the same source in the same cycle: set wins
        tbl[5] = 8'h40;
        irq[5] = 1'b1;
        cnt = 0; d5 = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            clear_valid = (k == SL + 1); clear_idx = 4'd5;
            step();
            if (obs_we) begin cnt++; d5 = obs_data; end
        end
        clear_valid = 1'b0;
        chk("t4_cnt", cnt, 1);
        chk("t4_data", d5, 8'h41);
        go_idle();

        // Two edges on irq[7] merged while 8..15 drain first
        clear_valid = 1'b1; clear_idx = 4'd7;
        step();
        clear_valid = 1'b0;
        repeat (4) step();
        irq = 16'hFF80;
        cnt7 = 0;
        for (int k = 1; k <= 20 + SL; k++) begin
            if (k == 2) irq[7] = 1'b0;
            if (k == 3) irq[7] = 1'b1;
            step();
            if (obs_we && obs_idx == 4'd7) cnt7++;
        end
        chk("t5_cnt7", cnt7, 1);
        chk("t5_ovf", obs_ovf, 1'b1);
        go_idle();
        chk("t5_ovf_sticky", obs_ovf, 1'b1);

        // Edge on irq[7] in the cycle its flag is taken
        do_reset();
        irq = 16'h00C0;
        cnt7 = 0;
        for (int k = 1; k <= 10 + SL; k++) begin
            if (k == 2) irq[7] = 1'b0;
            if (k == 3) irq[7] = 1'b1;
            step();
            if (obs_we && obs_idx == 4'd7) cnt7++;
        end
        chk("t5b_cnt7", cnt7, 2);
        chk("t5b_ovf", obs_ovf, 1'b0);
        go_idle();

        // Reset while writing with flags still queued
        do_reset();
        irq = 16'h001E;
        repeat (2 + SL) step();
        chk("t6_in_write", obs_we, 1'b1);
        #2;
        reset = 1'b1;
        irq = '0;
        model_reset();
        #1;
        chk("t6_we_drop", ext_write_enable, 1'b0);
        check_outputs();
        step(); step();
        reset = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 8 + SL; k++) begin
            step();
            if (obs_we) cnt++;
        end
        chk("t6_no_strobe", cnt, 0);
        chk("t6_busy", obs_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
